uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, maximum data bits per frame.
REQ-002 SHALL have parameter DIV_W, default 8, width of the baud divisor.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; power of 2, at least 2.
REQ-004 SHALL have ports: clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: cfg_en  in  1  transmitter enable.
REQ-007 SHALL have ports: cfg_br_div  in  DIV_W  bit period minus one, in clk cycles.
REQ-008 SHALL have ports: cfg_len  in  2  data length select; 0..3 gives DATA_W-3..DATA_W bits.
REQ-009 SHALL have ports: cfg_stop  in  1  stop bits; 0 = one, 1 = two.
REQ-010 SHALL have ports: wr_valid  in  1  write request; wr_data  in  DATA_W  write data.
REQ-011 SHALL have ports: wr_ready  out  1  equals NOT txf.
REQ-012 SHALL have ports: txf  out  1  FIFO full; tx  out  1  serial line, idle high.
REQ-013 SHALL have ports: busy  out  1  high when not IDLE; tx_done  out  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL accept a write only when wr_valid and wr_ready are both high; a write while full is dropped with no side effects.
REQ-015 SHALL derive wr_ready from the registered full flag only; a pop in the same cycle does not make a full FIFO writable.
REQ-016 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-026).
REQ-017 SHALL, in IDLE with cfg_en=1 and the FIFO non-empty, pop one entry, latch cfg_len/cfg_stop/cfg_br_div, and enter START next cycle.
REQ-018 SHALL produce a word-to-line latency of 2 cycles: a write accepted at edge N into an empty FIFO drives tx=0 after edge N+2.
REQ-019 SHALL hold each bit for cfg_br_div+1 cycles using a divisor counter; br_div=0 gives 1 cycle per bit.
REQ-020 SHALL send START as tx=0, DATA LSB-first for the latched length (upper bits ignored), then STOP as tx=1 for 1 or 2 bit periods.
REQ-021 SHALL pulse tx_done in the final cycle of STOP and return to IDLE; back-to-back frames have exactly one IDLE cycle between them.
REQ-022 SHALL not alter the current frame when config inputs change mid-frame; new values take effect at the next pop.
REQ-023 SHALL complete the current frame when cfg_en falls mid-frame, then start no new frame; FIFO contents are retained.
REQ-024 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with an extra pointer bit used to distinguish full from empty; simultaneous push and pop with the FIFO non-full and non-empty keeps the count unchanged.

Reset
REQ-025 SHALL, on rst assertion (immediately, even mid-frame), force tx=1, busy=0, tx_done=0, txf=0, wr_ready=1, state IDLE, pointers and counters to 0; FIFO contents are discarded.

Configuration
REQ-026 SHALL, with UART_TX_PARITY_EN defined, add input cfg_par (2 bits; 0 = none, 1 = even, 2 = odd, 3 = none), latched at pop, and a PARITY state of one bit period between DATA and STOP carrying the XOR of the sent data bits (inverted for odd).
REQ-027 SHALL, without UART_TX_PARITY_EN, omit the cfg_par port and the PARITY state; frames never contain a parity bit.

Verification
REQ-028 SHALL cover: br_div=3, len=3 (8 bits), stop=0, write 0xA5 -> tx low 2 cycles after accept; bits 1,0,1,0,0,1,0,1 at 4 cycles each; 4-cycle stop; tx_done pulse at cycle 40 of the frame.
REQ-029 SHALL cover: cfg_en=0, 5 writes with FIFO_DEPTH=4 -> txf=1 and wr_ready=0 after the 4th write; 5th dropped; enabling then transmits exactly 4 frames in order, each separated by 1 IDLE cycle.
REQ-030 SHALL cover: len=0 (5 bits), stop=1, br_div=0, data 0xFF -> 1 start bit, 5 ones, 2 stop bits; busy high for exactly 8 cycles.
REQ-031 SHALL cover: UART_TX_PARITY_EN defined, cfg_par=1 (even), data 0x07, len=3 -> parity bit 1; with cfg_par=2 (odd) -> parity bit 0.
REQ-032 SHALL cover: rst asserted mid-DATA with 2 entries queued -> tx=1 asynchronously; busy=0; after release no frame is sent until a new write.
REQ-033 SHALL cover: cfg_br_div changed from 3 to 1 mid-frame -> current frame keeps 4-cycle bits; next frame uses 2-cycle bits.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- UART transmitter fed by a small write FIFO.
//
// Words written through wr_valid/wr_ready are queued in a FIFO_DEPTH-entry
// buffer. While cfg_en is high the transmitter pops one word at a time,
// latches the frame configuration, and shifts out
//   start(0), DATA_W-3+cfg_len data bits LSB-first, [parity], 1 or 2 stop(1).
// Each bit lasts cfg_br_div+1 clk cycles.
//
// Optional feature macro: UART_TX_PARITY_EN adds the cfg_par input
// (0/3 = none, 1 = even, 2 = odd) and a one-bit-period PARITY state.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   cfg_en      transmitter enable (sampled only when idle)
//   cfg_br_div  bit period minus one, in clk cycles
//   cfg_len     data length select, 0..3 -> DATA_W-3..DATA_W bits
//   cfg_stop    0 = one stop bit, 1 = two stop bits
//   cfg_par     parity select (only with UART_TX_PARITY_EN)
//   wr_valid    write request
//   wr_data     write data
//   wr_ready    FIFO can accept a write (NOT txf)
//   txf         FIFO full
//   tx          serial line, idle high
//   busy        transmitter not idle
//   tx_done     one-cycle pulse in the last cycle of the stop period
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_br_div,
  input  logic [1:0]        cfg_len,
  input  logic              cfg_stop,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]        cfg_par,
`endif
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              txf,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NB_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  state_t            state;

  // Full/empty come straight from the registered pointers, so a pop in the
  // current cycle never opens a slot for a same-cycle write.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign txf      = full;
  assign wr_ready = ~full;
  assign push     = wr_valid & ~full;
  assign pop      = (state == S_IDLE) & cfg_en & ~empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // --------------------------------------------------------- transmitter
  logic [DATA_W-1:0] shreg;
  logic [NB_W-1:0]   nbits_q;
  logic [NB_W-1:0]   bit_idx;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  cnt;
  logic              stop_q;
  logic              stop_idx;
  logic              bit_end;
  logic              line;
`ifdef UART_TX_PARITY_EN
  logic [1:0]        par_q;
  logic              par_acc;
  logic              par_on;

  assign par_on = (par_q == 2'd1) || (par_q == 2'd2);
`endif

  assign bit_end = (cnt == div_q);

  always_comb begin
    line = 1'b1;
    case (state)
      S_IDLE:   line = 1'b1;
      S_START:  line = 1'b0;
      S_DATA:   line = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line = par_acc ^ (par_q == 2'd2);
`endif
      S_STOP:   line = 1'b1;
      default:  line = 1'b1;
    endcase
  end

  // Outputs are registered from the current state, so the line trails the
  // state by one cycle: the pop cycle in IDLE plus this register give the
  // two-cycle word-to-line latency, and busy/tx_done stay aligned with tx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      nbits_q  <= '0;
      bit_idx  <= '0;
      div_q    <= '0;
      cnt      <= '0;
      stop_q   <= 1'b0;
      stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= '0;
      par_acc  <= 1'b0;
`endif
      tx       <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx      <= line;
      busy    <= (state != S_IDLE);
      tx_done <= (state == S_STOP) && bit_end && (stop_idx == stop_q);

      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr[AW-1:0]];
            nbits_q  <= NB_W'(DATA_W - 3) + NB_W'(cfg_len);
            stop_q   <= cfg_stop;
            div_q    <= cfg_br_div;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= cfg_par;
            par_acc  <= 1'b0;
`endif
            state    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= S_DATA;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
`ifdef UART_TX_PARITY_EN
            par_acc <= par_acc ^ shreg[0];
`endif
            if (bit_idx == nbits_q - NB_W'(1)) begin
`ifdef UART_TX_PARITY_EN
              state <= par_on ? S_PARITY : S_STOP;
`else
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + NB_W'(1);
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= S_STOP;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (stop_idx == stop_q) begin
              state <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
